ndn_packet_rx: RTL and testbench
================================

// Module: ndn_packet_rx
// PURPOSE
//   Parametrised SPI-to-FIB packet receiver. Assembles the 8-bit byte stream from SPI (RX_valid/data_SPI_to_FIB)
//   into complete NDN interest or data packets. Presents each packet to the FIB on a valid/ready port.
//   Double-buffered: the next packet is received while the FIB still holds the previous one.
//   Sits between the SPI slave and the FIB packet decode logic.
// PARAMETERS
//   PREFIX_BYTES    8    prefix length in bytes (prefix width = 8*PREFIX_BYTES)
//   DATA_BYTES      32   data payload length in bytes (data packets only)
//   TIMEOUT_CYCLES  64   max consecutive idle cycles tolerated mid-packet before abort (>=2)
// PORTS
//   clk              in   1                 system clock
//   rst              in   1                 asynchronous, active-high reset
//   RX_valid         in   1                 data_SPI_to_FIB holds a new byte this cycle
//   data_SPI_to_FIB  in   8                 received byte
//   pkt_valid        out  1                 packet available on pkt_* outputs
//   pkt_ready        in   1                 FIB accepts packet (transfer = pkt_valid & pkt_ready)
//   pkt_is_data      out  1                 1 = data packet, 0 = interest packet
//   pkt_metadata     out  8                 metadata byte
//   pkt_prefix       out  8*PREFIX_BYTES    prefix, first received byte in MSBs
//   pkt_data         out  8*DATA_BYTES      payload, first byte in MSBs; all-zero for interests
//   rx_busy          out  1                 packet assembly in progress (state != IDLE)
//   err_timeout      out  1                 1-cycle pulse: packet aborted by gap timeout
//   err_overflow     out  1                 1-cycle pulse: completed packet dropped, output buffer full
//   err_checksum     out  1                 1-cycle pulse: checksum mismatch (CHECKSUM_EN only)
// BEHAVIOUR
//   Packet format, MSB-first on the wire:
//     interest = {metadata, prefix}; data = {metadata, prefix, payload}.
//   metadata[7] = 1 selects a data packet; metadata[6:0] is passed through unused.
//   Reset: FSM=IDLE, byte counter=0, shift regs=0. pkt_valid, pkt_is_data, pkt_metadata, pkt_prefix, pkt_data,
//     rx_busy and all err_* are 0.
//   A byte is accepted only on a clk edge with RX_valid=1. Every accepted byte is consumed; there is no SPI backpressure.
//   FSM:
//     IDLE:   accepted byte -> metadata reg, clear counter -> PREFIX.
//     PREFIX: shift byte in, count; on byte PREFIX_BYTES -> DATA if metadata[7], else COMPLETE.
//     DATA:   shift byte in, count; on byte DATA_BYTES -> COMPLETE.
//     CSUM:   (CHECKSUM_EN) one trailing byte, see CONFIGURATION.
//   COMPLETE is an action, not a state: FSM returns to IDLE on the same edge.
//     If the output buffer is free (or freed this cycle by a transfer), shift regs are copied to pkt_* and
//       pkt_valid is set; pkt_valid rises the cycle after the last byte is accepted.
//     If pkt_valid=1 and pkt_ready=0, the new packet is dropped, err_overflow pulses and the outputs are unchanged.
//   Output handshake:
//     pkt_* are stable while pkt_valid=1.
//     pkt_valid clears on transfer, unless a COMPLETE occurs the same cycle, in which case it stays 1 with new contents.
//   Gap timeout: counts consecutive RX_valid=0 cycles while the FSM is not IDLE. Reaching TIMEOUT_CYCLES -> IDLE,
//     partial packet discarded, err_timeout pulses, output buffer untouched. The count clears on any accepted byte.
//   rst mid-packet or with pkt_valid=1: everything returns to reset values; the pending packet is lost.
//   Back-to-back packets with no gap are supported: the byte after the final byte is the next metadata.
// CONFIGURATION
//   NDN_RX_CHECKSUM_EN defined:
//     - After the last prefix/payload byte the FSM enters CSUM and takes one more byte.
//     - Packet passes iff that byte == XOR of all preceding bytes (metadata included); it then completes normally.
//     - On mismatch: packet dropped, err_checksum pulses, FSM -> IDLE.
//     - Gap timeout also applies in CSUM.
//   Not defined: no CSUM state, no trailing byte; err_checksum is tied to 0.
// TESTING
//   1. Interest: metadata 0x30 + prefix 0x0000FFFF0000FFFF, one byte/cycle, pkt_ready=1 -> pkt_valid 1 cycle after
//      the 9th byte, pkt_is_data=0, prefix matches, pkt_data=0.
//   2. Data: metadata 0xB0, prefix 0x0123456789ABCDEF, payload bytes 0x00..0x1F -> pkt_is_data=1, pkt_data MSB byte
//      0x00, LSB byte 0x1F.
//   3. Overflow: hold pkt_ready=0, send two interests back-to-back -> first held stable, err_overflow pulses at the end
//      of the second; raise pkt_ready -> one transfer only.
//   4. Timeout: send metadata + 3 prefix bytes, then RX_valid=0 for TIMEOUT_CYCLES -> err_timeout pulse, rx_busy=0;
//      next full interest is received correctly.
//   5. Sparse/reset: RX_valid asserted every 3rd cycle -> correct packet. Assert rst after 5 bytes -> all outputs 0,
//      FSM IDLE.
//   6. NDN_RX_CHECKSUM_EN: interest 0x30 + 8x0xAA + checksum 0x30 -> accepted; checksum 0x31 -> err_checksum, no pkt_valid.

Source files
------------

// File: rtl/ndn_packet_rx_if.sv
// Bus bundle for ndn_packet_rx: SPI byte stream in, FIB packet valid/ready out,
// plus the status/error pulses.
interface ndn_packet_rx_if #(
    parameter int unsigned PREFIX_BYTES = 8,
    parameter int unsigned DATA_BYTES   = 32
);
    logic                      RX_valid;
    logic [7:0]                data_SPI_to_FIB;
    logic                      pkt_valid;
    logic                      pkt_ready;
    logic                      pkt_is_data;
    logic [7:0]                pkt_metadata;
    logic [8*PREFIX_BYTES-1:0] pkt_prefix;
    logic [8*DATA_BYTES-1:0]   pkt_data;
    logic                      rx_busy;
    logic                      err_timeout;
    logic                      err_overflow;
    logic                      err_checksum;

    // Environment side: SPI byte source and FIB consumer.
    modport master (
        output RX_valid, data_SPI_to_FIB, pkt_ready,
        input  pkt_valid, pkt_is_data, pkt_metadata, pkt_prefix, pkt_data,
               rx_busy, err_timeout, err_overflow, err_checksum
    );

    // Receiver side.
    modport slave (
        input  RX_valid, data_SPI_to_FIB, pkt_ready,
        output pkt_valid, pkt_is_data, pkt_metadata, pkt_prefix, pkt_data,
               rx_busy, err_timeout, err_overflow, err_checksum
    );
endinterface

// File: rtl/ndn_packet_rx.sv
// SPI-to-FIB NDN packet receiver. Assembles metadata/prefix/payload bytes into a
// packet held in a one-deep output buffer, so the next packet can be received while
// the FIB still holds the previous one.
// Optional trailing XOR checksum byte: define NDN_RX_CHECKSUM_EN.
module ndn_packet_rx #(
    parameter int unsigned PREFIX_BYTES   = 8,
    parameter int unsigned DATA_BYTES     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic            clk,
    input logic            rst,
    ndn_packet_rx_if.slave bus
);
    localparam int unsigned PW   = 8 * PREFIX_BYTES;
    localparam int unsigned DW   = 8 * DATA_BYTES;
    localparam int unsigned MAXB = (PREFIX_BYTES > DATA_BYTES) ? PREFIX_BYTES : DATA_BYTES;
    localparam int unsigned CW   = $clog2(MAXB + 1);
    localparam int unsigned GW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StPrefix,
`ifdef NDN_RX_CHECKSUM_EN
        StData,
        StCsum
`else
        StData
`endif
    } state_e;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gap;
    logic [7:0]      meta;
    logic [PW-1:0]   prefix_sr;
    logic [DW-1:0]   data_sr;
    logic [PW-1:0]   prefix_nx;
    logic [DW-1:0]   data_nx;

    logic            pkt_valid_q;
    logic            pkt_is_data_q;
    logic [7:0]      pkt_metadata_q;
    logic [PW-1:0]   pkt_prefix_q;
    logic [DW-1:0]   pkt_data_q;
    logic            err_timeout_q;
    logic            err_overflow_q;

    logic            accept;
    logic [7:0]      byte_in;
    logic            last_prefix;
    logic            last_data;
    logic            complete;
    logic            timeout;
    logic            buf_free;

    assign accept      = bus.RX_valid;
    assign byte_in     = bus.data_SPI_to_FIB;
    assign last_prefix = (cnt == CW'(PREFIX_BYTES - 1));
    assign last_data   = (cnt == CW'(DATA_BYTES - 1));
    assign timeout     = (state != StIdle) && !accept && (gap == GW'(TIMEOUT_CYCLES - 1));
    // A transfer this cycle frees the buffer for a packet completing on the same edge.
    assign buf_free    = !pkt_valid_q || bus.pkt_ready;

`ifdef NDN_RX_CHECKSUM_EN
    logic [7:0] csum;
    logic       err_checksum_q;
    logic       csum_bad;

    assign complete         = accept && (state == StCsum) && (byte_in == csum);
    assign csum_bad         = accept && (state == StCsum) && (byte_in != csum);
    assign bus.err_checksum = err_checksum_q;

    // Running XOR of every byte of the current packet, metadata included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum           <= '0;
            err_checksum_q <= 1'b0;
        end else begin
            err_checksum_q <= csum_bad;
            if (accept) csum <= (state == StIdle) ? byte_in : (csum ^ byte_in);
        end
    end
`else
    assign complete = accept && (((state == StPrefix) && last_prefix && !meta[7]) ||
                                 ((state == StData) && last_data));
    assign bus.err_checksum = 1'b0;
`endif

    // Shift-register contents including this cycle's byte, so a packet completing on
    // its last byte captures that byte.
    always_comb begin
        prefix_nx = prefix_sr;
        data_nx   = data_sr;
        if (accept && state == StPrefix) prefix_nx = (prefix_sr << 8) | PW'(byte_in);
        if (accept && state == StData)   data_nx   = (data_sr << 8) | DW'(byte_in);
    end

    // Receive FSM, gap timer and output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            cnt            <= '0;
            gap            <= '0;
            meta           <= '0;
            prefix_sr      <= '0;
            data_sr        <= '0;
            pkt_valid_q    <= 1'b0;
            pkt_is_data_q  <= 1'b0;
            pkt_metadata_q <= '0;
            pkt_prefix_q   <= '0;
            pkt_data_q     <= '0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            err_timeout_q  <= timeout;
            err_overflow_q <= complete && !buf_free;

            if (state == StIdle || accept || timeout) gap <= '0;
            else                                      gap <= gap + 1'b1;

            case (state)
                StIdle: if (accept) begin
                    meta      <= byte_in;
                    cnt       <= '0;
                    prefix_sr <= '0;
                    data_sr   <= '0;
                    state     <= StPrefix;
                end
                StPrefix: if (accept) begin
                    prefix_sr <= prefix_nx;
                    if (last_prefix) begin
                        cnt <= '0;
`ifdef NDN_RX_CHECKSUM_EN
                        state <= meta[7] ? StData : StCsum;
`else
                        state <= meta[7] ? StData : StIdle;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StData: if (accept) begin
                    data_sr <= data_nx;
                    if (last_data) begin
                        cnt <= '0;
`ifdef NDN_RX_CHECKSUM_EN
                        state <= StCsum;
`else
                        state <= StIdle;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef NDN_RX_CHECKSUM_EN
                StCsum: if (accept) state <= StIdle;
`endif
                default: state <= StIdle;
            endcase

            // Gap timeout discards the partial packet; the output buffer is untouched.
            if (timeout) begin
                state <= StIdle;
                cnt   <= '0;
            end

            if (complete && buf_free) begin
                pkt_valid_q    <= 1'b1;
                pkt_is_data_q  <= meta[7];
                pkt_metadata_q <= meta;
                pkt_prefix_q   <= prefix_nx;
                pkt_data_q     <= data_nx;
            end else if (pkt_valid_q && bus.pkt_ready) begin
                pkt_valid_q <= 1'b0;
            end
        end
    end

    assign bus.pkt_valid    = pkt_valid_q;
    assign bus.pkt_is_data  = pkt_is_data_q;
    assign bus.pkt_metadata = pkt_metadata_q;
    assign bus.pkt_prefix   = pkt_prefix_q;
    assign bus.pkt_data     = pkt_data_q;
    assign bus.rx_busy      = (state != StIdle);
    assign bus.err_timeout  = err_timeout_q;
    assign bus.err_overflow = err_overflow_q;
endmodule

// File: tb/tb_ndn_packet_rx.sv
// Directed bench for ndn_packet_rx with default parameters (8/32/64).
// Follows the checksum build when NDN_RX_CHECKSUM_EN is defined.
module tb_ndn_packet_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ndn_packet_rx_if #(.PREFIX_BYTES(8), .DATA_BYTES(32)) bus ();

    ndn_packet_rx #(
        .PREFIX_BYTES  (8),
        .DATA_BYTES    (32),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one edge; RX_valid is left high for back-to-back use.
    task automatic send(input logic [7:0] b);
        bus.RX_valid        = 1'b1;
        bus.data_SPI_to_FIB = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.RX_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Whole packet; spacing idle cycles after each byte, trailing checksum when enabled.
    task automatic send_pkt(input logic [7:0] meta, input logic [63:0] pfx,
                            input logic [255:0] pl, input int spacing, input bit corrupt);
        logic [7:0] x;
        int         nb;
        x = meta;
        send(meta);
        if (spacing > 0) idle(spacing);
        for (int i = 0; i < 8; i++) begin
            x = x ^ pfx[63-8*i -: 8];
            send(pfx[63-8*i -: 8]);
            if (spacing > 0) idle(spacing);
        end
        nb = meta[7] ? 32 : 0;
        for (int i = 0; i < nb; i++) begin
            x = x ^ pl[255-8*i -: 8];
            send(pl[255-8*i -: 8]);
            if (spacing > 0) idle(spacing);
        end
`ifdef NDN_RX_CHECKSUM_EN
        send(x ^ {7'd0, corrupt});
`endif
        bus.RX_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.RX_valid        = 1'b0;
        bus.data_SPI_to_FIB = 8'h00;
        bus.pkt_ready       = 1'b1;
        #12;
        check("rst_valid",    bus.pkt_valid, 0);
        check("rst_is_data",  bus.pkt_is_data, 0);
        check("rst_meta",     bus.pkt_metadata, 0);
        check("rst_prefix",   bus.pkt_prefix, 0);
        check("rst_data",     bus.pkt_data, 0);
        check("rst_busy",     bus.rx_busy, 0);
        check("rst_errs",     {bus.err_timeout, bus.err_overflow, bus.err_checksum}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: interest
        send_pkt(8'h30, 64'h0000FFFF0000FFFF, '0, 0, 1'b0);
        check("int_valid",   bus.pkt_valid, 1);
        check("int_is_data", bus.pkt_is_data, 0);
        check("int_meta",    bus.pkt_metadata, 8'h30);
        check("int_prefix",  bus.pkt_prefix, 64'h0000FFFF0000FFFF);
        check("int_data",    bus.pkt_data, 0);
        check("int_busy",    bus.rx_busy, 0);
        idle(1);
        check("int_xfer",    bus.pkt_valid, 0);

        // 2: data packet, payload 0x00..0x1F
        send_pkt(8'hB0, 64'h0123456789ABCDEF,
                 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F, 0, 1'b0);
        check("dat_valid",   bus.pkt_valid, 1);
        check("dat_is_data", bus.pkt_is_data, 1);
        check("dat_meta",    bus.pkt_metadata, 8'hB0);
        check("dat_prefix",  bus.pkt_prefix, 64'h0123456789ABCDEF);
        check("dat_data",
              bus.pkt_data,
              256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);
        idle(1);
        check("dat_xfer",    bus.pkt_valid, 0);

        // 3: overflow, two interests back-to-back with pkt_ready low
        bus.pkt_ready = 1'b0;
        send_pkt(8'h01, 64'h1111111111111111, '0, 0, 1'b0);
        check("ovf_first_valid",  bus.pkt_valid, 1);
        check("ovf_first_ovf",    bus.err_overflow, 0);
        send_pkt(8'h02, 64'h2222222222222222, '0, 0, 1'b0);
        check("ovf_pulse",        bus.err_overflow, 1);
        check("ovf_hold_meta",    bus.pkt_metadata, 8'h01);
        check("ovf_hold_prefix",  bus.pkt_prefix, 64'h1111111111111111);
        check("ovf_hold_valid",   bus.pkt_valid, 1);
        idle(1);
        check("ovf_pulse_end",    bus.err_overflow, 0);
        check("ovf_still_valid",  bus.pkt_valid, 1);
        bus.pkt_ready = 1'b1;
        idle(1);
        check("ovf_one_xfer",     bus.pkt_valid, 0);
        idle(2);
        check("ovf_no_second",    bus.pkt_valid, 0);

        // 4: gap timeout after metadata + 3 prefix bytes
        send(8'h30);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        idle(63);
        check("tmo_not_yet",  bus.err_timeout, 0);
        check("tmo_busy",     bus.rx_busy, 1);
        idle(1);
        check("tmo_pulse",    bus.err_timeout, 1);
        check("tmo_idle",     bus.rx_busy, 0);
        check("tmo_no_pkt",   bus.pkt_valid, 0);
        idle(1);
        check("tmo_pulse_end", bus.err_timeout, 0);
        send_pkt(8'h55, 64'hDEADBEEFCAFEF00D, '0, 0, 1'b0);
        check("tmo_next_valid",  bus.pkt_valid, 1);
        check("tmo_next_meta",   bus.pkt_metadata, 8'h55);
        check("tmo_next_prefix", bus.pkt_prefix, 64'hDEADBEEFCAFEF00D);
        idle(1);

        // 5: sparse bytes (every 3rd cycle), then reset mid-packet with a packet pending
        bus.pkt_ready = 1'b0;
        send_pkt(8'h12, 64'h0102030405060708, '0, 2, 1'b0);
        check("spr_valid",  bus.pkt_valid, 1);
        check("spr_meta",   bus.pkt_metadata, 8'h12);
        check("spr_prefix", bus.pkt_prefix, 64'h0102030405060708);
        send(8'hB0);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        bus.RX_valid = 1'b0;
        check("mid_busy", bus.rx_busy, 1);
        #2;
        rst = 1'b1;
        #2;
        check("mrst_valid",  bus.pkt_valid, 0);
        check("mrst_prefix", bus.pkt_prefix, 0);
        check("mrst_meta",   bus.pkt_metadata, 0);
        check("mrst_busy",   bus.rx_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.pkt_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", bus.pkt_valid, 0);
        send_pkt(8'h30, 64'hA5A5A5A55A5A5A5A, '0, 0, 1'b0);
        check("post_rst_is_data", bus.pkt_is_data, 0);
        check("post_rst_prefix",  bus.pkt_prefix, 64'hA5A5A5A55A5A5A5A);
        idle(1);

`ifdef NDN_RX_CHECKSUM_EN
        // 6: checksum pass (0x30) and fail (0x31)
        send_pkt(8'h30, 64'hAAAAAAAAAAAAAAAA, '0, 0, 1'b0);
        check("csum_ok_valid", bus.pkt_valid, 1);
        check("csum_ok_err",   bus.err_checksum, 0);
        idle(1);
        send_pkt(8'h30, 64'hAAAAAAAAAAAAAAAA, '0, 0, 1'b1);
        check("csum_bad_err",   bus.err_checksum, 1);
        check("csum_bad_valid", bus.pkt_valid, 0);
        idle(1);
        check("csum_bad_end",   bus.err_checksum, 0);
`else
        check("csum_tied_low", bus.err_checksum, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
